// File: rtl/npc_predict.sv
// -----------------------------------------------------------------------------
// npc_predict
//
// Fetch-stage next-PC generator. Holds the fetch PC register and predicts the
// next PC every cycle from a direct-mapped branch target buffer (BTB). Each
// BTB entry holds a valid bit, a tag, a target and a 2-bit saturating
// direction counter. The resolution stage redirects the PC on a mispredict
// and trains the BTB with resolved outcomes.
//
// Parameters:
//   XLEN         PC / target width
//   BTB_ENTRIES  number of BTB entries (power of two, >= 2)
//   RESET_PC     PC loaded on reset
//
// Ports:
//   clk             in   sole clock, rising edge
//   rst             in   synchronous active-high reset
//   stall           in   hold the current PC
//   redirect_valid  in   load redirect_pc (wins over stall)
//   redirect_pc     in   corrected next PC
//   upd_valid       in   train the BTB with a resolved branch/jump
//   upd_pc          in   PC of the resolved instruction
//   upd_taken       in   resolved direction
//   upd_target      in   resolved target (meaningful when taken)
//   pc              out  current fetch PC (registered)
//   pred_taken      out  predicted direction for pc (combinational)
//   pred_target     out  predicted next PC for pc (combinational)
// -----------------------------------------------------------------------------
module npc_predict #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   output logic [XLEN-1:0] pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target
);

   localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
   localparam int unsigned TAGW = XLEN - 2 - IDX;

   // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
   localparam logic [1:0] CTR_WEAK_T = 2'b10;

   // Fetch PC and BTB storage
   logic [XLEN-1:0]        r_pc;
   logic [BTB_ENTRIES-1:0] r_valid;
   logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]        r_target [BTB_ENTRIES];
   logic [1:0]             r_ctr    [BTB_ENTRIES];

   // Lookup side (current fetch PC)
   logic [IDX-1:0]  w_idx;
   logic [TAGW-1:0] w_tag;
   logic            w_hit;
   logic [XLEN-1:0] w_pc_plus4;
   logic            w_pred_taken;
   logic [XLEN-1:0] w_pred_target;

   // Training side (resolved PC)
   logic [IDX-1:0]  w_uidx;
   logic [TAGW-1:0] w_utag;
   logic            w_uhit;
   logic [1:0]      w_ctr_next;

   // Byte-offset bits of upd_pc play no part in indexing or tagging.
   logic            w_unused;
   assign w_unused = &{1'b0, upd_pc[1:0]};

   // ---------------------------------------------------------------------------
   // Lookup: reads pre-edge BTB contents only, so a same-cycle update to the
   // entry being looked up is not bypassed.
   // ---------------------------------------------------------------------------
   assign w_idx         = r_pc[IDX+1:2];
   assign w_tag         = r_pc[XLEN-1:IDX+2];
   assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_pc_plus4    = r_pc + XLEN'(4);
   assign w_pred_taken  = w_hit && r_ctr[w_idx][1];
   assign w_pred_target = w_pred_taken ? r_target[w_idx] : w_pc_plus4;

   assign pc          = r_pc;
   assign pred_taken  = w_pred_taken;
   assign pred_target = w_pred_target;

   // ---------------------------------------------------------------------------
   // Training lookup and saturating counter step
   // ---------------------------------------------------------------------------
   assign w_uidx = upd_pc[IDX+1:2];
   assign w_utag = upd_pc[XLEN-1:IDX+2];
   assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

   always_comb begin
      // NOTE: assign a default before any branch so every path drives
      // w_ctr_next and no latch is inferred.
      w_ctr_next = r_ctr[w_uidx];
      if (upd_taken) begin
         if (r_ctr[w_uidx] != 2'b11) w_ctr_next = r_ctr[w_uidx] + 2'd1;
      end else begin
         if (r_ctr[w_uidx] != 2'b00) w_ctr_next = r_ctr[w_uidx] - 2'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // PC register and valid bits. Priority: rst > redirect > stall > predict.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_valid <= '0;
      end else begin
         // NOTE: non-blocking assignments make every read in this edge see the
         // pre-edge state, so redirect, prediction and training stay independent.
         if (redirect_valid) begin
            r_pc <= redirect_pc;
         end else if (!stall) begin
            r_pc <= w_pred_target;
         end

         // Only a taken miss allocates; hits keep their valid bit set.
         if (upd_valid && !w_uhit && upd_taken) begin
            r_valid[w_uidx] <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // BTB payload. Training is suppressed while rst is high.
   // ---------------------------------------------------------------------------
   // NOTE: tags, targets and counters are deliberately not reset; a cleared
   // valid bit already hides whatever they hold.
   always_ff @(posedge clk) begin
      if (!rst && upd_valid) begin
         if (w_uhit) begin
            r_ctr[w_uidx] <= w_ctr_next;
            if (upd_taken) r_target[w_uidx] <= upd_target;
         end else if (upd_taken) begin
            // Miss and taken: allocate, overwriting any aliasing entry.
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
            r_ctr[w_uidx]    <= CTR_WEAK_T;
         end
      end
   end

endmodule

// File: tb/tb_npc_predict.sv
// -----------------------------------------------------------------------------
// tb_npc_predict
//
// Self-checking bench for npc_predict (default parameters: XLEN=32,
// BTB_ENTRIES=16, RESET_PC=0). A table of hand-derived vectors walks through
// sequential fetch, allocation, counter hysteresis, priority, aliasing, the
// same-cycle update hazard and PC wrap. Hand-written sequences cover reset
// colliding with redirect/update. A randomized phase compares every cycle
// against a behavioural model of the BTB built from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_npc_predict;

   localparam int unsigned NE = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;

   int n_checks = 0;
   int n_errors = 0;

   npc_predict #(
      .XLEN        (32),
      .BTB_ENTRIES (NE),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .pc             (pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model: BTB as plain arrays, index/tag by division.
   // ---------------------------------------------------------------------------
   int unsigned m_pc;
   bit          m_valid  [NE];
   int unsigned m_tag    [NE];
   int unsigned m_target [NE];
   int          m_ctr    [NE];

   function automatic void model_lookup(input int unsigned a, output bit t, output int unsigned tg);
      int unsigned i;
      bit hit;
      i   = (a / 4) % NE;
      hit = m_valid[i] && (m_tag[i] == a / (4 * NE));
      t   = hit && (m_ctr[i] >= 2);
      tg  = t ? m_target[i] : a + 4;
   endfunction

   function automatic void model_edge(input bit r, s, rv, input int unsigned rpc,
                                      input bit uv, input int unsigned upc,
                                      input bit ut, input int unsigned utg);
      bit          t;
      int unsigned tg, i;
      if (r) begin
         m_pc = 0;
         for (int k = 0; k < NE; k++) m_valid[k] = 1'b0;
         return;
      end
      model_lookup(m_pc, t, tg);
      if (uv) begin
         i = (upc / 4) % NE;
         if (m_valid[i] && m_tag[i] == upc / (4 * NE)) begin
            if (ut) begin
               m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_target[i] = utg;
            end else begin
               m_ctr[i]    = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (ut) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = upc / (4 * NE);
            m_target[i] = utg;
            m_ctr[i]    = 2;
         end
      end
      if (rv)      m_pc = rpc;
      else if (!s) m_pc = tg;
   endfunction

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model at the
   // rising edge, and return 1 time unit later with outputs settled.
   task automatic do_cycle(input logic r, s, rv, input logic [31:0] rpc,
                           input logic uv, input logic [31:0] upc,
                           input logic ut, input logic [31:0] utg);
      @(negedge clk);
      rst            = r;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rpc;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_taken      = ut;
      upd_target     = utg;
      @(posedge clk);
      model_edge(r, s, rv, rpc, uv, upc, ut, utg);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] e_pc,
                            input logic e_t, input logic [31:0] e_tg);
      check({tag, " pc"},          pc,                  e_pc);
      check({tag, " pred_taken"},  {31'b0, pred_taken}, {31'b0, e_t});
      check({tag, " pred_target"}, pred_target,         e_tg);
   endtask

   task automatic check_model(input string tag);
      bit          t;
      int unsigned tg;
      model_lookup(m_pc, t, tg);
      check_out(tag, m_pc, t, tg);
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table: inputs for one edge, outputs expected after it.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        s;
      logic        rv;
      logic [31:0] rpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utg;
      logic [31:0] e_pc;
      logic        e_t;
      logic [31:0] e_tg;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic s, rv, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg, input logic [31:0] e_pc,
                      input logic e_t, input logic [31:0] e_tg);
      vec_t v;
      v.s = s; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc; v.ut = ut;
      v.utg = utg; v.e_pc = e_pc; v.e_t = e_t; v.e_tg = e_tg;
      vecs.push_back(v);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //     s  rv rpc           uv upc           ut utg           e_pc          e_t e_tg
      // sequential fetch after reset
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4,        0, 32'h8);
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h8,        0, 32'hC);
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hC,        0, 32'h10);
      // allocate 0x10 -> 0x40, then predicted taken on arrival
      add(0, 0, 32'h0,        1, 32'h10,       1, 32'h40,       32'h10,       1, 32'h40);
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h40,       0, 32'h44);
      // redirect + not-taken update same PC: ctr 10 -> 01
      add(0, 1, 32'h10,       1, 32'h10,       0, 32'h0,        32'h10,       0, 32'h14);
      // stalled 3 cycles while training: 01->10->11->10
      add(1, 0, 32'h0,        1, 32'h10,       1, 32'h40,       32'h10,       1, 32'h40);
      add(1, 0, 32'h0,        1, 32'h10,       1, 32'h40,       32'h10,       1, 32'h40);
      add(1, 0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h10,       1, 32'h40);
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h40,       0, 32'h44);
      // redirect beats stall, then stall alone holds, then resume at +4
      add(1, 1, 32'h200,      0, 32'h0,        0, 32'h0,        32'h200,      0, 32'h204);
      add(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h200,      0, 32'h204);
      add(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h200,      0, 32'h204);
      add(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h200,      0, 32'h204);
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h204,      0, 32'h208);
      // aliasing: 0x50 shares index with 0x10 and evicts it
      add(0, 0, 32'h0,        1, 32'h50,       1, 32'h80,       32'h208,      0, 32'h20C);
      add(0, 1, 32'h10,       0, 32'h0,        0, 32'h0,        32'h10,       0, 32'h14);
      add(0, 1, 32'h50,       0, 32'h0,        0, 32'h0,        32'h50,       1, 32'h80);
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80,       0, 32'h84);
      // same-cycle hazard at 0x84: no bypass, later visit predicts
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h84,       0, 32'h88);
      add(0, 0, 32'h0,        1, 32'h84,       1, 32'h300,      32'h88,       0, 32'h8C);
      add(0, 1, 32'h84,       0, 32'h0,        0, 32'h0,        32'h84,       1, 32'h300);
      // pc+4 wraps modulo 2^32
      add(0, 1, 32'hFFFF_FFFC, 0, 32'h0,       0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0);
      add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h4);

      // Reset and its visible state
      do_cycle(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      check_out("reset", 32'h0, 1'b0, 32'h4);

      foreach (vecs[k]) begin
         do_cycle(0, vecs[k].s, vecs[k].rv, vecs[k].rpc, vecs[k].uv,
                  vecs[k].upc, vecs[k].ut, vecs[k].utg);
         check_out($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_t, vecs[k].e_tg);
      end

      // rst together with redirect and a taken update: rst wins, BTB cleared
      do_cycle(1, 0, 1, 32'h300, 1, 32'h0, 1, 32'h500);
      check_out("rst_over_all", 32'h0, 1'b0, 32'h4);
      do_cycle(0, 0, 1, 32'h84, 0, 32'h0, 0, 32'h0);
      check_out("rst_cleared_84", 32'h84, 1'b0, 32'h88);
      do_cycle(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      check_out("rst_cleared_seq", 32'h88, 1'b0, 32'h8C);

      // Randomized phase against the behavioural model
      do_cycle(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      check_model("rand_reset");
      for (int n = 0; n < 3000; n++) begin
         logic        r, s, rv, uv, ut;
         logic [31:0] rpc, upc, utg;
         r   = ($urandom_range(0, 99) == 0);
         s   = ($urandom_range(0, 3) == 0);
         rv  = ($urandom_range(0, 9) == 0);
         uv  = ($urandom_range(0, 9) < 4);
         ut  = 1'($urandom_range(0, 1));
         rpc = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                           : 32'($urandom_range(0, 127)) * 4;
         upc = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(0, 3));
         utg = 32'($urandom_range(0, 127)) * 4;
         do_cycle(r, s, rv, rpc, uv, upc, ut, utg);
         check_model($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/npc_predict.md
# npc_predict

Fetch-stage next-PC generator with a parametrised direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It owns the fetch PC register, predicts the next PC every cycle, and accepts redirects and training updates from the branch-resolution stage. It is the registered, predicting successor of the combinational next-PC adder: the pipeline no longer waits for resolution to leave PC+4.

## Interface

Parameters:
- XLEN, 32, PC/target width.
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the current PC (hazard unit).
- redirect_valid  in  1  resolution stage detected a mispredict; load redirect_pc.
- redirect_pc  in  XLEN  correct next PC.
- upd_valid  in  1  a branch/jump resolved; train the BTB.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  XLEN  resolved target (valid when upd_taken=1).
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  prediction for pc (combinational from pc and BTB).
- pred_target  out  XLEN  predicted next PC for pc (target if pred_taken, else pc+4).

## Operation

- BTB entry: valid (1), tag (XLEN-2-IDX), target (XLEN), ctr (2).
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]. pc[1:0] is ignored.
- Lookup: hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? target : pc+4 (modulo 2^XLEN; wrap from 32'hFFFF_FFFC gives 0).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturating at 00 and 11.
- Next-PC priority at each edge: rst > redirect_valid > stall > pred_target.
  - rst: pc ← RESET_PC; all valid bits ← 0 (tags, targets, and counters need not be cleared).
  - redirect_valid: pc ← redirect_pc, regardless of stall.
  - stall: pc unchanged.
  - else: pc ← pred_target.
- Training on upd_valid (independent of stall/redirect; suppressed by rst):
  - hit at upd_pc: ctr ← ctr+1 if taken, ctr−1 if not (saturating); target ← upd_target if taken.
  - miss and taken: allocate/overwrite entry; valid←1, tag, target←upd_target, ctr←10.
  - miss and not taken: no change.
- Lookup reads pre-edge contents; no bypass of a same-cycle update, even at the same index.

## Timing

- Reset: one edge with rst=1. Next cycle pc=RESET_PC, pred_taken=0, pred_target=RESET_PC+4.
- pc is registered; pred_taken/pred_target are valid combinationally in the same cycle as pc.
- Redirect latency: redirect_valid at cycle N → pc=redirect_pc in cycle N+1.
- Training latency: update at cycle N is visible to lookups from cycle N+1.
- Stall with no redirect: pc, and hence the predictions, hold for as long as stall is high.
- rst mid-operation overrides redirect, stall, and update in that cycle.
- Simultaneous redirect and update to the same PC: both take effect. The next lookup at redirect_pc sees the trained entry.
- Aliasing: a different tag at the same index is a miss. A taken update overwrites the entry.

## Test plan

- Reset/sequential: rst 1 cycle, RESET_PC=0, no other inputs → pc sequence 0,4,8,12; pred_taken=0 throughout.
- Allocate and predict: upd_valid, upd_pc=0x10, taken, target=0x40 at cycle N → when pc later reaches 0x10, pred_taken=1 (ctr=10), next pc=0x40.
- Counter hysteresis: from ctr=10 at 0x10, one not-taken update → ctr=01, pred_taken=0. Two taken updates → ctr=11. One not-taken → ctr=10, still predicted taken.
- Priority: stall=1 and redirect_valid=1 with redirect_pc=0x200 → pc=0x200 next cycle. Stall alone for 3 cycles → pc held, then resumes at pc+4.
- Aliasing (BTB_ENTRIES=16): train 0x10 taken→0x40, then 0x50 taken→0x80 (same index) → lookup at 0x10 misses (pred_target=0x14), 0x50 predicts 0x80.
- Same-cycle hazard: upd at 0x10 (taken) while pc=0x10 with an empty BTB → pred_taken=0 that cycle; a later visit to 0x10 predicts taken. rst asserted together with upd_valid → BTB empty afterward.
